// File: rtl/bus_pkg.sv
// Shared definitions for the 68000-style asynchronous bus responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

    // Bus geometry: A[23:1] word address, 16-bit data.
    localparam int BUS_ADDR_W = 23;
    localparam int BUS_DATA_W = 16;

    // Polarity of the active-low bus strobes (AS, UDS, LDS, DTACK).
    localparam logic ASSERTED_L = 1'b0;
    localparam logic NEGATED_L  = 1'b1;

    // Responder bus-cycle states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        WAIT   = 3'd2,
        ACK    = 3'd3,
        HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/responder_ram.sv
// Single-port word RAM with per-byte write enables backing the responder.
// Latency: registered read, data valid one cycle after the address is presented.
// Backpressure: none; a read or write is accepted every cycle.
module responder_ram
    import bus_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                  clk,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [BUS_DATA_W-1:0] wdata,
    input  logic                  we_hi,
    input  logic                  we_lo,
    output logic [BUS_DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [BUS_DATA_W-1:0] mem [DEPTH];

    // Byte-lane writes plus read-first registered read of the same address.
    always_ff @(posedge clk) begin
        if (we_hi) begin
            mem[addr][15:8] <= wdata[15:8];
        end
        if (we_lo) begin
            mem[addr][7:0] <= wdata[7:0];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_responder.sv
// Slave end of the 68000-style async bus: decode, RAM read/write, wait states, DTACK.
// Latency: AS sampled low at edge k gives DTACK low after edge k+2+WAIT_STATES.
// Backpressure: DTACK is held until AS negates; AS negated before ACK aborts the cycle.
module bus_responder
    import bus_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int BASE        = 0,
    parameter int WAIT_STATES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [BUS_ADDR_W-1:0] A,
    input  logic                  AS,
    input  logic                  UDS,
    input  logic                  LDS,
    input  logic                  RW,
    input  logic [BUS_DATA_W-1:0] D_IN,
    output logic [BUS_DATA_W-1:0] D_OUT,
    output logic                  D_OE,
    output logic                  DTACK
);

    // Upper address bits compared against BASE to select this block.
    localparam int             SEL_W    = BUS_ADDR_W - ADDR_BITS;
    localparam logic [SEL_W-1:0] BASE_SEL = SEL_W'(BASE);
    localparam logic [3:0]     WS_CNT   = 4'(WAIT_STATES);

    state_t state;
    state_t state_nxt;

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    // Cycle attributes captured when the cycle is accepted in IDLE.
    logic                 latch_en;
    logic [ADDR_BITS-1:0] idx_q;
    logic                 rw_q;
    logic                 uds_q;
    logic                 lds_q;

    // Registered bus outputs and their next values.
    logic                  dtack_q;
    logic                  dtack_nxt;
    logic                  oe_q;
    logic                  oe_nxt;
    logic [BUS_DATA_W-1:0] dout_q;
    logic [BUS_DATA_W-1:0] dout_nxt;

    logic                  sel;
    logic                  strobe_any;
    logic                  as_neg;

    logic                  ram_we_hi;
    logic                  ram_we_lo;
    logic [BUS_DATA_W-1:0] ram_rdata;

    assign sel        = (A[BUS_ADDR_W-1:ADDR_BITS] == BASE_SEL);
    assign strobe_any = (UDS == ASSERTED_L) || (LDS == ASSERTED_L);
    assign as_neg     = (AS == NEGATED_L);

    assign DTACK = dtack_q;
    assign D_OE  = oe_q;
    assign D_OUT = dout_q;

    // The RAM always looks at the latched index, so the read issued in
    // DECODE (and repeated through WAIT) is ready when ACK is reached.
    responder_ram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk   (CLK),
        .addr  (idx_q),
        .wdata (D_IN),
        .we_hi (ram_we_hi),
        .we_lo (ram_we_lo),
        .rdata (ram_rdata)
    );

    // State, wait counter and registered outputs; reset returns to idle bus levels.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            dtack_q <= NEGATED_L;
            oe_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dtack_q <= dtack_nxt;
            oe_q    <= oe_nxt;
            dout_q  <= dout_nxt;
        end
    end

    // Capture address index, direction and lane strobes at cycle acceptance.
    always_ff @(posedge CLK) begin
        if (latch_en) begin
            idx_q <= A[ADDR_BITS-1:0];
            rw_q  <= RW;
            uds_q <= UDS;
            lds_q <= LDS;
        end
    end

    // Next-state logic: accept, count wait states, acknowledge, hold until AS negates.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_en  = 1'b0;
        case (state)
            IDLE: begin
                // Unselected or strobe-less cycles are never answered.
                if ((AS == ASSERTED_L) && sel && strobe_any) begin
                    state_nxt = DECODE;
                    latch_en  = 1'b1;
                end
            end
            DECODE: begin
                if (as_neg) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt   = WS_CNT;
                    state_nxt = (WS_CNT == 4'd0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                // Counter starts at WAIT_STATES, so WAIT lasts exactly that many cycles.
                if (as_neg) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd1) begin
                    state_nxt = ACK;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ACK: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (as_neg) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Next output values and RAM write strobes for the current state.
    always_comb begin
        dtack_nxt = NEGATED_L;
        oe_nxt    = 1'b0;
        dout_nxt  = '0;
        ram_we_hi = 1'b0;
        ram_we_lo = 1'b0;
        case (state)
            ACK: begin
                dtack_nxt = ASSERTED_L;
                if (rw_q) begin
                    oe_nxt   = 1'b1;
                    dout_nxt = ram_rdata;
                end else begin
                    // A reset landing on the ACK edge drops the write.
                    ram_we_hi = (uds_q == ASSERTED_L) && !RESET;
                    ram_we_lo = (lds_q == ASSERTED_L) && !RESET;
                end
            end
            HOLD: begin
                if (!as_neg) begin
                    dtack_nxt = dtack_q;
                    oe_nxt    = oe_q;
                    dout_nxt  = dout_q;
                end
            end
            default: begin
                dtack_nxt = NEGATED_L;
                oe_nxt    = 1'b0;
                dout_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: six instances with different WAIT_STATES/BASE share one bus.
// An edge-counting transaction model predicts DTACK/D_OE/D_OUT of every instance each cycle.
// Directed bus cycles pin latency and data values with literal expectations.
module tb_bus_responder;

    localparam int NI    = 6;
    localparam int AB    = 10;
    localparam int DEPTH = 1 << AB;

    // Per-instance configuration: WAIT_STATES and BASE.
    function automatic int ws_of(input int i);
        case (i)
            0:       return 2;
            1:       return 0;
            2:       return 1;
            3:       return 7;
            4:       return 5;
            default: return 2;
        endcase
    endfunction

    function automatic int base_of(input int i);
        return (i == 5) ? 1 : 0;
    endfunction

    logic        CLK = 1'b0;
    logic        RESET;
    logic [22:0] A;
    logic        AS;
    logic        UDS;
    logic        LDS;
    logic        RW;
    logic [15:0] D_IN;

    logic [15:0] d_out [NI];
    logic        d_oe  [NI];
    logic        dtack [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bus_responder #(
            .ADDR_BITS   (AB),
            .BASE        (base_of(g)),
            .WAIT_STATES (ws_of(g))
        ) u_dut (
            .CLK   (CLK),
            .RESET (RESET),
            .A     (A),
            .AS    (AS),
            .UDS   (UDS),
            .LDS   (LDS),
            .RW    (RW),
            .D_IN  (D_IN),
            .D_OUT (d_out[g]),
            .D_OE  (d_oe[g]),
            .DTACK (dtack[g])
        );
    end

    // ---------------- behavioural model ----------------
    int unsigned   edge_n = 0;
    bit            m_ready = 0;
    bit            m_act   [NI];
    bit            m_acked [NI];
    int unsigned   m_start [NI];
    logic [AB-1:0] m_idx   [NI];
    bit            m_rw    [NI];
    bit            m_uds   [NI];
    bit            m_lds   [NI];
    logic [15:0]   m_mem   [NI][DEPTH];
    bit            m_khi   [NI][DEPTH];
    bit            m_klo   [NI][DEPTH];
    logic          e_dtack [NI];
    logic          e_oe    [NI];
    logic [15:0]   e_dout  [NI];
    bit            e_known [NI];

    // One call per rising edge: a cycle accepted at edge S is acknowledged
    // at edge S+2+WS; AS high on any edge before that cancels it; after the
    // acknowledge the outputs hold until an edge sees AS high.
    task automatic model_step();
        int unsigned ws;
        bit          sel;
        edge_n++;
        for (int i = 0; i < NI; i++) begin
            ws  = ws_of(i);
            sel = (int'(A[22:AB]) == base_of(i));
            if (RESET) begin
                m_act[i]   = 0;
                e_dtack[i] = 1'b1;
                e_oe[i]    = 1'b0;
                e_dout[i]  = 16'h0000;
                e_known[i] = 1;
            end else if (!m_act[i]) begin
                if (!AS && sel && (!UDS || !LDS)) begin
                    m_act[i]   = 1;
                    m_acked[i] = 0;
                    m_start[i] = edge_n;
                    m_idx[i]   = A[AB-1:0];
                    m_rw[i]    = RW;
                    m_uds[i]   = UDS;
                    m_lds[i]   = LDS;
                end
            end else if (!m_acked[i]) begin
                if (edge_n == m_start[i] + 2 + ws) begin
                    m_acked[i] = 1;
                    e_dtack[i] = 1'b0;
                    if (m_rw[i]) begin
                        e_oe[i]    = 1'b1;
                        e_dout[i]  = m_mem[i][m_idx[i]];
                        e_known[i] = m_khi[i][m_idx[i]] && m_klo[i][m_idx[i]];
                    end else begin
                        if (!m_uds[i]) begin
                            m_mem[i][m_idx[i]][15:8] = D_IN[15:8];
                            m_khi[i][m_idx[i]] = 1;
                        end
                        if (!m_lds[i]) begin
                            m_mem[i][m_idx[i]][7:0] = D_IN[7:0];
                            m_klo[i][m_idx[i]] = 1;
                        end
                    end
                end else if (AS) begin
                    m_act[i] = 0;
                end
            end else if (AS) begin
                m_act[i]   = 0;
                e_dtack[i] = 1'b1;
                e_oe[i]    = 1'b0;
                e_dout[i]  = 16'h0000;
                e_known[i] = 1;
            end
        end
        if (RESET) m_ready = 1;
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    // Per-cycle comparison of every instance against the model.
    initial begin
        bit ok;
        forever begin
            @(negedge CLK);
            if (m_ready) begin
                for (int i = 0; i < NI; i++) begin
                    ok = (dtack[i] === e_dtack[i]) && (d_oe[i] === e_oe[i]) &&
                         (!e_known[i] || (d_out[i] === e_dout[i]));
                    n_tests++;
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL model inst%0d edge %0d: got dtack=%b oe=%b dout=%h, want dtack=%b oe=%b dout=%h",
                                 i, edge_n, dtack[i], d_oe[i], d_out[i], e_dtack[i], e_oe[i], e_dout[i]);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // One master cycle aimed at instance ti; returns edges from AS sample to DTACK.
    task automatic bus_cycle(input int ti, input logic [22:0] addr, input logic rw,
                             input logic uds, input logic lds, input logic [15:0] din,
                             input int hold, output int lat, output logic [15:0] rd,
                             output logic oe);
        int n;
        bit got;
        @(negedge CLK);
        A = addr; RW = rw; UDS = uds; LDS = lds; D_IN = din; AS = 1'b0;
        n = 0; got = 0; lat = -1; rd = 16'h0000; oe = 1'b0;
        while (!got && n < 40) begin
            @(posedge CLK); #1;
            n++;
            if (dtack[ti] == 1'b0) begin
                got = 1;
                lat = n - 1;
                rd  = d_out[ti];
                oe  = d_oe[ti];
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL dtack_timeout inst%0d: dtack=%b after %0d edges, want 0", ti, dtack[ti], n);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            check("dtack_hold", {31'd0, dtack[ti]}, 32'd0);
            check("oe_hold", {31'd0, d_oe[ti]}, {31'd0, rw});
        end
        @(negedge CLK);
        AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
        @(posedge CLK); #1;
        check("dtack_release", {31'd0, dtack[ti]}, 32'd1);
        check("oe_release", {31'd0, d_oe[ti]}, 32'd0);
    endtask

    task automatic rand_fields();
        logic [12:0] up;
        logic [9:0]  ix;
        up  = ($urandom_range(0, 7) == 0) ? 13'd1 : 13'd0;
        ix  = 10'($urandom_range(0, 31));
        A   = {up, ix};
        RW  = 1'($urandom_range(0, 1));
        UDS = ($urandom_range(0, 2) == 0);
        LDS = ($urandom_range(0, 2) == 0);
    endtask

    // Bound on total run time.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          lat;
        logic [15:0] rd;
        logic        oe;
        bit          seen;
        int          low_n;
        int          high_n;

        RESET = 1'b1; AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
        A = 23'd0; D_IN = 16'h0000;
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("reset_dtack", {31'd0, dtack[i]}, 32'd1);
            check("reset_oe", {31'd0, d_oe[i]}, 32'd0);
            check("reset_dout", {16'd0, d_out[i]}, 32'd0);
        end
        @(negedge CLK);
        RESET = 1'b0;

        // Word write then read, WS=2.
        bus_cycle(0, 23'h000010, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0, lat, rd, oe);
        check("write_latency_ws2", lat, 32'd4);
        bus_cycle(0, 23'h000010, 1'b1, 1'b0, 1'b0, 16'h0000, 2, lat, rd, oe);
        check("read_beef", {16'd0, rd}, 32'h0000BEEF);
        check("read_oe", {31'd0, oe}, 32'd1);
        check("read_latency_ws2", lat, 32'd4);

        // Byte lanes.
        bus_cycle(0, 23'd5, 1'b0, 1'b0, 1'b0, 16'h1234, 0, lat, rd, oe);
        bus_cycle(0, 23'd5, 1'b0, 1'b0, 1'b1, 16'hAB00, 0, lat, rd, oe);
        bus_cycle(0, 23'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 0, lat, rd, oe);
        check("upper_lane", {16'd0, rd}, 32'h0000AB34);
        bus_cycle(0, 23'd5, 1'b0, 1'b1, 1'b0, 16'h00CD, 0, lat, rd, oe);
        bus_cycle(0, 23'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 0, lat, rd, oe);
        check("lower_lane", {16'd0, rd}, 32'h0000ABCD);

        // Wait-state sweep with DTACK held for a few cycles.
        bus_cycle(1, 23'h000010, 1'b1, 1'b0, 1'b0, 16'h0000, 3, lat, rd, oe);
        check("latency_ws0", lat, 32'd2);
        check("read_ws0", {16'd0, rd}, 32'h0000BEEF);
        bus_cycle(2, 23'h000010, 1'b1, 1'b0, 1'b0, 16'h0000, 3, lat, rd, oe);
        check("latency_ws1", lat, 32'd3);
        bus_cycle(3, 23'h000010, 1'b1, 1'b0, 1'b0, 16'h0000, 3, lat, rd, oe);
        check("latency_ws7", lat, 32'd9);

        // Unselected address for the BASE=1 instance.
        bus_cycle(5, 23'h000403, 1'b0, 1'b0, 1'b0, 16'h5A5A, 0, lat, rd, oe);
        @(negedge CLK);
        A = 23'h000003; RW = 1'b0; UDS = 1'b0; LDS = 1'b0; D_IN = 16'hFFFF; AS = 1'b0;
        seen = 0;
        repeat (50) begin
            @(posedge CLK); #1;
            if (dtack[5] !== 1'b1 || d_oe[5] !== 1'b0) seen = 1;
        end
        check("unselected_quiet", {31'd0, seen}, 32'd0);
        @(negedge CLK);
        AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
        bus_cycle(5, 23'h000403, 1'b1, 1'b0, 1'b0, 16'h0000, 0, lat, rd, oe);
        check("unselected_ram_kept", {16'd0, rd}, 32'h00005A5A);

        // Abort in WAIT, WS=5.
        bus_cycle(4, 23'd7, 1'b0, 1'b0, 1'b0, 16'h1111, 0, lat, rd, oe);
        @(negedge CLK);
        A = 23'd7; RW = 1'b0; UDS = 1'b0; LDS = 1'b0; D_IN = 16'hFFFF; AS = 1'b0;
        seen = 0;
        repeat (3) begin
            @(posedge CLK); #1;
            if (dtack[4] == 1'b0) seen = 1;
        end
        @(negedge CLK);
        AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
        repeat (10) begin
            @(posedge CLK); #1;
            if (dtack[4] == 1'b0) seen = 1;
        end
        check("abort_no_dtack", {31'd0, seen}, 32'd0);
        bus_cycle(4, 23'd7, 1'b1, 1'b0, 1'b0, 16'h0000, 0, lat, rd, oe);
        check("abort_word_kept", {16'd0, rd}, 32'h00001111);
        check("after_abort_latency", lat, 32'd7);

        // Reset during HOLD of a read.
        @(negedge CLK);
        A = 23'h000010; RW = 1'b1; UDS = 1'b0; LDS = 1'b0; AS = 1'b0;
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge CLK); #1;
            if (dtack[0] == 1'b0) seen = 1;
        end
        check("pre_reset_dtack_seen", {31'd0, seen}, 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("reset_mid_dtack", {31'd0, dtack[0]}, 32'd1);
        check("reset_mid_oe", {31'd0, d_oe[0]}, 32'd0);
        check("reset_mid_dout", {16'd0, d_out[0]}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0; AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
        bus_cycle(0, 23'h000010, 1'b1, 1'b0, 1'b0, 16'h0000, 0, lat, rd, oe);
        check("after_reset_read", {16'd0, rd}, 32'h0000BEEF);

        // Randomized traffic: varying hold times, mid-cycle input changes,
        // unselected and strobe-less cycles, occasional resets.
        for (int it = 0; it < 1500; it++) begin
            low_n  = $urandom_range(1, 12);
            high_n = $urandom_range(1, 3);
            @(negedge CLK);
            rand_fields();
            D_IN = 16'($urandom);
            AS   = 1'b0;
            for (int c = 1; c < low_n; c++) begin
                @(negedge CLK);
                D_IN  = 16'($urandom);
                RESET = ($urandom_range(0, 40) == 0);
                if ($urandom_range(0, 3) == 0) rand_fields();
            end
            @(negedge CLK);
            RESET = 1'b0;
            AS    = 1'b1;
            for (int c = 1; c < high_n; c++) @(negedge CLK);
        end

        repeat (5) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Slave/responder end of the 68000-style asynchronous bus that the V68k core drives as initiator.
- Decodes A/AS/UDS/LDS/RW, serves reads and writes from an internal word-wide RAM, inserts programmable wait states and returns DTACK.
- Sits on the system bus beside the CPU as the first memory target for core bring-up and bus-cycle verification.

Parameters:
- ADDR_BITS, 10, number of word-address bits of internal RAM (2^ADDR_BITS 16-bit words)
- BASE, 0, value A[23:ADDR_BITS+1] must equal for this block to respond
- WAIT_STATES, 2, extra cycles between decode and DTACK assertion (0..15)

Ports:
- CLK  in  1  system clock; all inputs sampled on rising edge
- RESET  in  1  synchronous, active-high reset
- A  in  23  word address A[23:1]
- AS  in  1  address strobe, active-low
- UDS  in  1  upper data strobe, active-low, lane D[15:8]
- LDS  in  1  lower data strobe, active-low, lane D[7:0]
- RW  in  1  high = read, low = write
- D_IN  in  16  write data from bus
- D_OUT  out  16  read data to bus
- D_OE  out  1  high = drive D_OUT onto bus (tri-state enable for top level)
- DTACK  out  1  data transfer acknowledge, active-low

Behaviour:
- Reset, and the default when no cycle is being served: DTACK=1, D_OE=0, D_OUT=0, state IDLE.
- RAM contents are not cleared by RESET.
- Sel = (A[23:ADDR_BITS+1] == BASE).
- Word index = A[ADDR_BITS:1].
- FSM states: IDLE, DECODE, WAIT, ACK, HOLD. All outputs are registered.
- IDLE:
  - AS=0 and Sel=1 and (UDS=0 or LDS=0) → DECODE.
  - Latch the word index, RW, UDS, LDS.
  - Otherwise stay in IDLE. An unselected cycle never gets DTACK; bus timeout belongs to the system.
- DECODE:
  - Issue the RAM read of the latched index. Load wait counter = WAIT_STATES.
  - Go to ACK if WAIT_STATES==0, else to WAIT.
- WAIT:
  - Decrement the counter; go to ACK when it reaches 1.
  - Spends exactly WAIT_STATES cycles.
- ACK entry (single cycle):
  - DTACK←0.
  - Read: D_OUT←RAM data and D_OE←1. Both lanes are driven; the master ignores the unused lane.
  - Write: write D_IN sampled this cycle into the lanes enabled by the latched UDS/LDS. Unenabled lanes are unchanged.
  - Next state HOLD.
- HOLD:
  - Keep DTACK=0 and D_OE (for reads) while AS=0.
  - On AS=1 sampled: DTACK←1, D_OE←0, go to IDLE.
- Latency: AS low sampled at edge k → DTACK low after edge k+2+WAIT_STATES.
- Early abort: AS=1 sampled in DECODE or WAIT → IDLE. No write, no DTACK, D_OE stays 0.
- Back-to-back cycles: AS must be seen high at least one edge before a new cycle is accepted. The IDLE visit guarantees DTACK negates before the next cycle.
- RW, UDS, LDS and A changing after the IDLE latch are ignored for the current cycle. D_IN is sampled only on the ACK entry edge.
- RESET in any state: next cycle is the reset outputs and IDLE. An in-flight write is dropped unless the ACK edge has already occurred.
- UDS=LDS=1 with AS=0: not a data cycle; ignored.
- Counter width: 4 bits.

Decomposition:
- Shared package bus_pkg:
  - FSM state typedef (IDLE..HOLD).
  - Polarity constants ASSERTED_L=0, NEGATED_L=1.
  - Bus address width 23 and data width 16.
- One sub-module responder_ram:
  - Single-port synchronous RAM, 2^ADDR_BITS x 16.
  - Ports: clk, addr, wdata, we_hi, we_lo, rdata.
  - Registered read, one-cycle latency.
- The responder top holds the FSM, decode and output registers.

Test Plan:
- Word write/read, WAIT_STATES=2, BASE=0:
  - Write 0xBEEF to A=0x000010 with UDS=LDS=0, RW=0 → DTACK low exactly 4 edges after AS sampled low.
  - Read of the same address → D_OUT=0xBEEF, D_OE=1 while DTACK=0.
- Byte lanes:
  - Preload 0x1234 at word 5, write D_IN=0xAB00 with UDS=0, LDS=1 → readback 0xAB34.
  - Then write 0x00CD with LDS only → readback 0xABCD.
- Wait-state sweep WAIT_STATES=0,1,7:
  - DTACK asserts 2/3/9 edges after AS.
  - DTACK holds until AS negates, then goes high the following edge.
- Unselected address, BASE=1, A[23:11]=0:
  - AS held low 50 cycles → DTACK stays 1, D_OE stays 0, RAM unchanged.
- Abort in WAIT (WAIT_STATES=5):
  - AS negated 3 cycles into a write of 0xFFFF → no DTACK; word retains its prior value; next cycle is served normally.
- Reset mid-cycle:
  - RESET pulsed during HOLD of a read → next edge DTACK=1, D_OE=0, state IDLE.
  - Earlier-written RAM data is still readable afterwards.
